// File: rtl/rvga_mem_arbiter.sv
// rvga_mem_arbiter: shares one single-port memory bus between instruction fetch and data access; define RVGA_ARB_RR_EN for round-robin tie-breaking
module rvga_mem_arbiter (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        imem_r_v_i,
  input  logic [31:0] imem_addr_i,
  output logic [31:0] imem_data_o,
  output logic        imem_resp_v_o,
  input  logic        dmem_r_v_i,
  input  logic        dmem_w_v_i,
  input  logic [31:0] dmem_addr_i,
  input  logic [31:0] dmem_data_i,
  input  logic [3:0]  dmem_wmask_i,
  output logic [31:0] dmem_data_o,
  output logic        dmem_resp_v_o,
  output logic        mem_req_v_o,
  input  logic        mem_req_ready_i,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wmask_o,
  input  logic        mem_resp_v_i,
  input  logic [31:0] mem_rdata_i
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t state, state_nxt;
  logic gnt_d, dreq, tie_d, win_d, grant;
  assign dreq  = dmem_r_v_i | dmem_w_v_i;
  assign grant = state == IDLE && (imem_r_v_i || dreq);
`ifdef RVGA_ARB_RR_EN
  logic last_d;
  assign tie_d = ~last_d;
`else
  assign tie_d = 1'b1;
`endif
  assign win_d = dreq && (!imem_r_v_i || tie_d);
  assign mem_req_v_o   = state == REQ;
  assign imem_resp_v_o = state == RESP && !gnt_d;
  assign dmem_resp_v_o = state == RESP && gnt_d;
  // state register
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) state <= IDLE;
    else state <= state_nxt;
  // next state; requests are only looked at in IDLE so a held request is not reissued from RESP
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = grant ? REQ : IDLE;
      REQ:  state_nxt = mem_req_ready_i ? WAIT : REQ;
      WAIT: state_nxt = mem_resp_v_i ? RESP : WAIT;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // latch the granted request onto the bus and capture read data for the granted side
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      gnt_d       <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_wmask_o <= '0;
      imem_data_o <= '0;
      dmem_data_o <= '0;
`ifdef RVGA_ARB_RR_EN
      last_d      <= 1'b0;
`endif
    end else begin
      if (grant) begin
        gnt_d       <= win_d;
        mem_we_o    <= win_d && dmem_w_v_i;
        mem_addr_o  <= win_d ? dmem_addr_i : imem_addr_i;
        mem_wdata_o <= win_d && dmem_w_v_i ? dmem_data_i : '0;
        mem_wmask_o <= win_d && dmem_w_v_i ? dmem_wmask_i : '0;
`ifdef RVGA_ARB_RR_EN
        last_d      <= win_d;
`endif
      end
      if (state == WAIT && mem_resp_v_i && !gnt_d) imem_data_o <= mem_rdata_i;
      if (state == WAIT && mem_resp_v_i && gnt_d && !mem_we_o) dmem_data_o <= mem_rdata_i;
    end
endmodule

// File: tb/tb_rvga_mem_arbiter.sv
// tb_rvga_mem_arbiter: directed self-checking bench for rvga_mem_arbiter
module tb_rvga_mem_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        imem_r_v = 1'b0, dmem_r_v = 1'b0, dmem_w_v = 1'b0;
  logic [31:0] imem_addr = '0, dmem_addr = '0, dmem_data = '0, rdata = '0;
  logic [3:0]  dmem_wmask = '0;
  logic        ready = 1'b0, resp_v = 1'b0;
  logic [31:0] imem_data_o, dmem_data_o, mem_addr, mem_wdata;
  logic        imem_resp_v, dmem_resp_v, req_v, we;
  logic [3:0]  mem_wmask;
  int errors = 0, checks = 0;
  logic exp_d;

  rvga_mem_arbiter dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .imem_r_v_i(imem_r_v), .imem_addr_i(imem_addr),
    .imem_data_o(imem_data_o), .imem_resp_v_o(imem_resp_v),
    .dmem_r_v_i(dmem_r_v), .dmem_w_v_i(dmem_w_v), .dmem_addr_i(dmem_addr),
    .dmem_data_i(dmem_data), .dmem_wmask_i(dmem_wmask),
    .dmem_data_o(dmem_data_o), .dmem_resp_v_o(dmem_resp_v),
    .mem_req_v_o(req_v), .mem_req_ready_i(ready), .mem_we_o(we),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_wmask_o(mem_wmask),
    .mem_resp_v_i(resp_v), .mem_rdata_i(rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    @(negedge clk);
    chk("rst_req_v", {31'b0, req_v}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_resp", {30'b0, imem_resp_v, dmem_resp_v}, 0);
    chk("rst_data", imem_data_o | dmem_data_o, 0);
    rst_n = 1'b1;
    // fetch, best-case latency
    imem_r_v = 1'b1; imem_addr = 32'h100; ready = 1'b1;
    @(negedge clk);
    chk("f_req_v", {31'b0, req_v}, 1);
    chk("f_addr", mem_addr, 32'h100);
    chk("f_we_mask", {27'b0, we, mem_wmask}, 0);
    imem_r_v = 1'b0;
    @(negedge clk);
    chk("f_wait_req_v", {31'b0, req_v}, 0);
    resp_v = 1'b1; rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("f_resp_v", {30'b0, imem_resp_v, dmem_resp_v}, 32'h2);
    chk("f_data", imem_data_o, 32'hDEADBEEF);
    resp_v = 1'b0;
    @(negedge clk);
    chk("f_single_pulse", {31'b0, imem_resp_v}, 0);
    chk("f_data_hold", imem_data_o, 32'hDEADBEEF);
    // store, request held through RESP
    dmem_w_v = 1'b1; dmem_addr = 32'h2004; dmem_data = 32'h12345678; dmem_wmask = 4'h3;
    @(negedge clk);
    chk("w_we", {31'b0, we}, 1);
    chk("w_addr", mem_addr, 32'h2004);
    chk("w_wdata", mem_wdata, 32'h12345678);
    chk("w_wmask", {28'b0, mem_wmask}, 32'h3);
    @(negedge clk);
    resp_v = 1'b1; rdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("w_resp_v", {30'b0, imem_resp_v, dmem_resp_v}, 32'h1);
    chk("w_data_unchanged", dmem_data_o, 0);
    resp_v = 1'b0;
    @(negedge clk);
    chk("w_no_reissue", {31'b0, req_v}, 0);
    chk("w_pulse_end", {31'b0, dmem_resp_v}, 0);
    dmem_w_v = 1'b0;
    @(negedge clk);
    chk("w_idle", {31'b0, req_v}, 0);
    // both sides requesting continuously; last grant was D
    for (int k = 0; k < 4; k++) begin
      imem_r_v = 1'b1; dmem_r_v = 1'b1; imem_addr = 32'h500; dmem_addr = 32'h600;
      ready = 1'b1; resp_v = 1'b1; rdata = 32'hA000 + k;
`ifdef RVGA_ARB_RR_EN
      exp_d = (k % 2) == 1;
`else
      exp_d = 1'b1;
`endif
      repeat (3) @(negedge clk);
      chk($sformatf("arb%0d_side", k), {30'b0, imem_resp_v, dmem_resp_v}, exp_d ? 32'h1 : 32'h2);
      chk($sformatf("arb%0d_data", k), exp_d ? dmem_data_o : imem_data_o, 32'hA000 + k);
      @(negedge clk);
    end
    // not-ready for 5 cycles; core inputs change but bus stays stable
    imem_r_v = 1'b0; dmem_r_v = 1'b1; dmem_addr = 32'h300; ready = 1'b0; resp_v = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall%0d_req_v", i), {31'b0, req_v}, 1);
      chk($sformatf("stall%0d_addr", i), mem_addr, 32'h300);
      chk($sformatf("stall%0d_we_mask", i), {27'b0, we, mem_wmask}, 0);
      dmem_addr = 32'hBAD0 + i;
      @(negedge clk);
    end
    chk("stall_req_v6", {31'b0, req_v}, 1);
    chk("stall_addr6", mem_addr, 32'h300);
    ready = 1'b1;
    @(negedge clk);
    chk("stall_accepted", {31'b0, req_v}, 0);
    resp_v = 1'b1; rdata = 32'h55AA55AA;
    @(negedge clk);
    chk("stall_resp_v", {31'b0, dmem_resp_v}, 1);
    chk("stall_data", dmem_data_o, 32'h55AA55AA);
    resp_v = 1'b0; dmem_r_v = 1'b0;
    @(negedge clk);
    // reset during WAIT, then a stale bus response
    imem_r_v = 1'b1; imem_addr = 32'h400;
    @(negedge clk);
    imem_r_v = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("ar_req_v", {31'b0, req_v}, 0);
    chk("ar_addr", mem_addr, 0);
    chk("ar_data", imem_data_o | dmem_data_o, 0);
    chk("ar_resp", {30'b0, imem_resp_v, dmem_resp_v}, 0);
    @(negedge clk);
    rst_n = 1'b1; resp_v = 1'b1; rdata = 32'hFFFF;
    @(negedge clk);
    chk("stale_resp", {30'b0, imem_resp_v, dmem_resp_v}, 0);
    chk("stale_req_v", {31'b0, req_v}, 0);
    resp_v = 1'b0;
    @(negedge clk);
    chk("stale_data", imem_data_o | dmem_data_o, 0);
    imem_r_v = 1'b1; dmem_r_v = 1'b1; imem_addr = 32'h700; dmem_addr = 32'h800;
    @(negedge clk);
    chk("tie_req_v", {31'b0, req_v}, 1);
    chk("tie_d_wins", mem_addr, 32'h800);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
